// File: rtl/sitcp_tx_mux_if.sv
// Bundles the SiTCP TX byte port with the per-channel FWFT FIFO read ports.
// The mux drives the master side; the SiTCP core and user FIFOs sit on slave.
interface sitcp_tx_mux_if #(
  parameter int N_CH = 4
);
  logic                 MAIN_OPEN_ACK;
  logic                 TX_FULL;
  logic                 TX_WR;
  logic [7:0]           TX_DATA;
  logic [16*N_CH-1:0]   CH_AVAIL;
  logic [8*N_CH-1:0]    CH_DATA;
  logic [N_CH-1:0]      CH_RE;

  modport master (
    input  MAIN_OPEN_ACK,
    input  TX_FULL,
    input  CH_AVAIL,
    input  CH_DATA,
    output TX_WR,
    output TX_DATA,
    output CH_RE
  );

  modport slave (
    output MAIN_OPEN_ACK,
    output TX_FULL,
    output CH_AVAIL,
    output CH_DATA,
    input  TX_WR,
    input  TX_DATA,
    input  CH_RE
  );
endinterface

// File: rtl/sitcp_tx_mux.sv
// Round-robin multi-channel front end for the SiTCP TX byte port: each burst is
// framed as {tag,channel}, length-1, then up to MAX_BURST payload bytes.
module sitcp_tx_mux #(
  parameter int         N_CH      = 4,
  parameter int         CH_W      = 2,
  parameter int         MAX_BURST = 64,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic                CLK,
  input  logic                RST,
  sitcp_tx_mux_if.master      bus,
  output logic                BUSY,
  output logic [CH_W-1:0]     CUR_CH,
  output logic [15:0]         ABORT_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_cur_ch;
  logic [CH_W-1:0]   w_cur_ch_nxt;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [8:0]        r_len;
  logic [8:0]        w_len_nxt;
  logic [8:0]        r_remain;
  logic [8:0]        w_remain_nxt;
  logic              r_tx_wr;
  logic              w_tx_wr_nxt;
  logic [7:0]        r_tx_data;
  logic [7:0]        w_tx_data_nxt;
  logic [15:0]       r_abort_cnt;
  logic [15:0]       w_abort_cnt_nxt;
  logic [N_CH-1:0]   w_ch_re;

  logic [15:0]       w_avail [N_CH];
  logic [7:0]        w_data  [N_CH];
  logic              w_grant_found;
  logic [CH_W-1:0]   w_grant_ch;
  logic [15:0]       w_grant_avail;
  logic [8:0]        w_grant_len;
  logic [3:0]        w_ch_nib;

  // Channel index arithmetic modulo N_CH; collapses to 0 when N_CH is 1.
  function automatic logic [CH_W-1:0] chAdd(input logic [CH_W-1:0] base, input int k);
    chAdd = CH_W'((int'(base) + k) % N_CH);
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_avail[i] = bus.CH_AVAIL[16*i +: 16];
      w_data[i]  = bus.CH_DATA[8*i +: 8];
    end
  end

  // Walk from the far end back toward the pointer so the nearest ready channel wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_ch    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_avail[chAdd(r_ptr, k)] != 16'd0) begin
        w_grant_found = 1'b1;
        w_grant_ch    = chAdd(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_grant_avail = w_avail[w_grant_ch];
    w_grant_len   = (w_grant_avail > 16'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(w_grant_avail);
    w_ch_nib      = '0;
    w_ch_nib[CH_W-1:0] = r_cur_ch;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_ch_nxt    = r_cur_ch;
    w_ptr_nxt       = r_ptr;
    w_len_nxt       = r_len;
    w_remain_nxt    = r_remain;
    w_tx_wr_nxt     = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_abort_cnt_nxt = r_abort_cnt;
    w_ch_re         = '0;

    case (r_state)
      IDLE: begin
        if (bus.MAIN_OPEN_ACK && w_grant_found) begin
          w_cur_ch_nxt = w_grant_ch;
          w_len_nxt    = w_grant_len;
          w_state_nxt  = HDR0;
        end
      end

      default: begin
        // Connection loss outranks backpressure; unread bytes stay upstream.
        if (!bus.MAIN_OPEN_ACK) begin
          w_state_nxt     = IDLE;
          w_ptr_nxt       = chAdd(r_cur_ch, 1);
          w_abort_cnt_nxt = (r_abort_cnt == 16'hFFFF) ? r_abort_cnt : r_abort_cnt + 16'd1;
        end else if (!bus.TX_FULL) begin
          w_tx_wr_nxt = 1'b1;
          case (r_state)
            HDR0: begin
              w_tx_data_nxt = {HDR_TAG, w_ch_nib};
              w_state_nxt   = HDR1;
            end
            HDR1: begin
              w_tx_data_nxt = 8'(r_len - 9'd1);
              w_remain_nxt  = r_len;
              w_state_nxt   = DATA;
            end
            default: begin
              w_tx_data_nxt     = w_data[r_cur_ch];
              w_ch_re[r_cur_ch] = 1'b1;
              w_remain_nxt      = r_remain - 9'd1;
              if (r_remain == 9'd1) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = chAdd(r_cur_ch, 1);
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cur_ch    <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_remain    <= '0;
      r_tx_wr     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_abort_cnt <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_ch    <= w_cur_ch_nxt;
      r_ptr       <= w_ptr_nxt;
      r_len       <= w_len_nxt;
      r_remain    <= w_remain_nxt;
      r_tx_wr     <= w_tx_wr_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_abort_cnt <= w_abort_cnt_nxt;
    end
  end

  // A pop during the reset cycle would lose a byte that is never sent.
  assign bus.CH_RE   = RST ? '0 : w_ch_re;
  assign bus.TX_WR   = r_tx_wr;
  assign bus.TX_DATA = r_tx_data;
  assign BUSY        = (r_state != IDLE);
  assign CUR_CH      = r_cur_ch;
  assign ABORT_CNT   = r_abort_cnt;

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Directed bench for sitcp_tx_mux: FWFT FIFO models on every channel, a logger
// of the SiTCP TX stream, and per-scenario expected byte streams.
module tb_sitcp_tx_mux;
  localparam int N_CH      = 4;
  localparam int CH_W      = 2;
  localparam int MAX_BURST = 64;

  logic             CLK = 1'b0;
  logic             RST;
  logic             BUSY;
  logic [CH_W-1:0]  CUR_CH;
  logic [15:0]      ABORT_CNT;

  sitcp_tx_mux_if #(.N_CH(N_CH)) bus ();

  sitcp_tx_mux #(
    .N_CH      (N_CH),
    .CH_W      (CH_W),
    .MAX_BURST (MAX_BURST),
    .HDR_TAG   (4'hA)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .BUSY      (BUSY),
    .CUR_CH    (CUR_CH),
    .ABORT_CNT (ABORT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    logic       busy;
  } txRec_t;

  typedef struct {
    int         ch;
    int         n;
    logic [7:0] seed;
    logic [7:0] expHdr0;
    logic [7:0] expHdr1;
    int         expSpan;
  } vec_t;

  logic [7:0] fifoMem [N_CH][512];
  int         wrPtr    [N_CH] = '{default: 0};
  int         rdPtr    [N_CH] = '{default: 0};
  int         popCount [N_CH] = '{default: 0};
  int         stallPops = 0;
  int         cyc = 0;
  txRec_t     txLog [$];
  logic [7:0] expQ [$];
  int         nChecks = 0;
  int         nFails  = 0;

  // FIFO pops land after the DUT has captured the head byte on the same edge.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.CH_RE[i]) begin
        rdPtr[i]    <= rdPtr[i] + 1;
        popCount[i] <= popCount[i] + 1;
        if (bus.TX_FULL) stallPops <= stallPops + 1;
      end
    end
  end

  always_comb begin
    bus.CH_AVAIL = '0;
    bus.CH_DATA  = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.CH_AVAIL[16*i +: 16] = 16'(wrPtr[i] - rdPtr[i]);
      bus.CH_DATA[8*i +: 8]    = fifoMem[i][rdPtr[i] % 512];
    end
  end

  always begin
    @(posedge CLK);
    #1;
    if (bus.TX_WR === 1'b1) txLog.push_back('{bus.TX_DATA, cyc, BUSY});
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic loadChannel(input int ch, input int n, input logic [7:0] seed);
    for (int j = 0; j < n; j++) begin
      fifoMem[ch][wrPtr[ch] % 512] = seed + 8'(j);
      wrPtr[ch] = wrPtr[ch] + 1;
    end
  endtask

  task automatic expectFrame(input logic [7:0] h0, input logic [7:0] h1, input int n, input logic [7:0] first);
    expQ.push_back(h0);
    expQ.push_back(h1);
    for (int j = 0; j < n; j++) expQ.push_back(first + 8'(j));
  endtask

  task automatic waitLogSize(input string name, input int target, input int budget);
    int n = 0;
    while (txLog.size() < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({name, " stream reached"}, 32'(txLog.size() >= target), 32'd1);
  endtask

  task automatic compareLog(input string name, input int base);
    int got;
    got = txLog.size() - base;
    checkOutput({name, " byte count"}, 32'(got), 32'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < got; k++)
      checkOutput($sformatf("%s byte %0d", name, k), 32'(txLog[base + k].data), 32'(expQ[k]));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int    base;
    int    pop0;
    string name;
    name = $sformatf("vec%0d ch%0d", idx, v.ch);
    base = txLog.size();
    pop0 = popCount[v.ch];
    expQ.delete();
    @(negedge CLK);
    loadChannel(v.ch, v.n, v.seed);
    expectFrame(v.expHdr0, v.expHdr1, v.n, v.seed);
    waitLogSize(name, base + v.n + 2, 4 * v.n + 20);
    repeat (4) @(negedge CLK);
    compareLog(name, base);
    if (txLog.size() >= base + v.n + 2) begin
      checkOutput({name, " span"}, 32'(txLog[base + v.n + 1].cyc - txLog[base].cyc), 32'(v.expSpan));
      checkOutput({name, " busy at header"}, 32'(txLog[base].busy), 32'd1);
      checkOutput({name, " busy at last byte"}, 32'(txLog[base + v.n + 1].busy), 32'd0);
    end
    checkOutput({name, " pops"}, 32'(popCount[v.ch] - pop0), 32'(v.n));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [4];
    int   base;
    int   pop0;
    int   stall0;

    vecs[0] = '{0,  5, 8'h01, 8'hA0, 8'h04,  6};
    vecs[1] = '{3,  1, 8'h40, 8'hA3, 8'h00,  2};
    vecs[2] = '{1, 64, 8'h80, 8'hA1, 8'h3F, 65};
    vecs[3] = '{2, 16, 8'hF8, 8'hA2, 8'h0F, 17};

    RST = 1'b1;
    bus.MAIN_OPEN_ACK = 1'b1;
    bus.TX_FULL = 1'b0;
    doReset();
    checkOutput("reset TX_WR", 32'(bus.TX_WR), 32'd0);
    checkOutput("reset TX_DATA", 32'(bus.TX_DATA), 32'h00);
    checkOutput("reset CH_RE", 32'(bus.CH_RE), 32'd0);
    checkOutput("reset BUSY", 32'(BUSY), 32'd0);
    checkOutput("reset CUR_CH", 32'(CUR_CH), 32'd0);
    checkOutput("reset ABORT_CNT", 32'(ABORT_CNT), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Oversized request splits into a full burst and a remainder burst.
    base = txLog.size();
    expQ.delete();
    @(negedge CLK);
    loadChannel(2, 100, 8'h10);
    expectFrame(8'hA2, 8'h3F, 64, 8'h10);
    expectFrame(8'hA2, 8'h23, 36, 8'h50);
    waitLogSize("split", base + 104, 300);
    repeat (4) @(negedge CLK);
    compareLog("split", base);
    if (txLog.size() >= base + 104)
      checkOutput("split gap", 32'(txLog[base + 66].cyc - txLog[base + 65].cyc), 32'd2);

    // Round robin, with ch0 refilled mid-burst to show LEN is frozen at grant.
    doReset();
    base = txLog.size();
    expQ.delete();
    @(negedge CLK);
    loadChannel(0, 2, 8'h00);
    loadChannel(1, 2, 8'h10);
    loadChannel(3, 2, 8'h30);
    repeat (3) @(negedge CLK);
    loadChannel(0, 2, 8'h02);
    expectFrame(8'hA0, 8'h01, 2, 8'h00);
    expectFrame(8'hA1, 8'h01, 2, 8'h10);
    expectFrame(8'hA3, 8'h01, 2, 8'h30);
    expectFrame(8'hA0, 8'h01, 2, 8'h02);
    waitLogSize("rr", base + 16, 100);
    repeat (4) @(negedge CLK);
    compareLog("rr", base);

    // Three-cycle TX_FULL stall in the middle of a 10-byte payload.
    base = txLog.size();
    pop0 = popCount[0];
    stall0 = stallPops;
    expQ.delete();
    @(negedge CLK);
    loadChannel(0, 10, 8'h20);
    expectFrame(8'hA0, 8'h09, 10, 8'h20);
    waitLogSize("stall pre", base + 4, 20);
    bus.TX_FULL = 1'b1;
    repeat (3) @(negedge CLK);
    bus.TX_FULL = 1'b0;
    waitLogSize("stall", base + 12, 40);
    repeat (4) @(negedge CLK);
    compareLog("stall", base);
    if (txLog.size() >= base + 12)
      checkOutput("stall span", 32'(txLog[base + 11].cyc - txLog[base].cyc), 32'd14);
    checkOutput("stall pops while full", 32'(stallPops - stall0), 32'd0);
    checkOutput("stall pops", 32'(popCount[0] - pop0), 32'd10);

    // Connection drop after three payload bytes, then reopen.
    base = txLog.size();
    pop0 = popCount[1];
    expQ.delete();
    @(negedge CLK);
    loadChannel(1, 8, 8'h60);
    waitLogSize("abort pre", base + 5, 30);
    bus.MAIN_OPEN_ACK = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("abort no more writes", 32'(txLog.size() - base), 32'd5);
    checkOutput("abort ABORT_CNT", 32'(ABORT_CNT), 32'd1);
    checkOutput("abort BUSY", 32'(BUSY), 32'd0);
    checkOutput("abort pops", 32'(popCount[1] - pop0), 32'd3);
    loadChannel(2, 2, 8'h90);
    repeat (3) @(negedge CLK);
    checkOutput("closed no grant", 32'(BUSY), 32'd0);
    bus.MAIN_OPEN_ACK = 1'b1;
    expQ.push_back(8'hA1);
    expQ.push_back(8'h07);
    expQ.push_back(8'h60);
    expQ.push_back(8'h61);
    expQ.push_back(8'h62);
    expectFrame(8'hA2, 8'h01, 2, 8'h90);
    expectFrame(8'hA1, 8'h04, 5, 8'h63);
    waitLogSize("abort", base + 16, 60);
    repeat (4) @(negedge CLK);
    compareLog("abort", base);

    // Reset while in HDR1 drops the partial frame and clears the abort count.
    base = txLog.size();
    expQ.delete();
    @(negedge CLK);
    loadChannel(3, 3, 8'hC0);
    waitLogSize("rst pre", base + 1, 20);
    checkOutput("rst CUR_CH before", 32'(CUR_CH), 32'd3);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("rst TX_WR", 32'(bus.TX_WR), 32'd0);
    checkOutput("rst BUSY", 32'(BUSY), 32'd0);
    checkOutput("rst ABORT_CNT", 32'(ABORT_CNT), 32'd0);
    checkOutput("rst CUR_CH", 32'(CUR_CH), 32'd0);
    checkOutput("rst CH_RE", 32'(bus.CH_RE), 32'd0);
    RST = 1'b0;
    expQ.push_back(8'hA3);
    expectFrame(8'hA3, 8'h02, 3, 8'hC0);
    waitLogSize("rst", base + 6, 30);
    repeat (4) @(negedge CLK);
    compareLog("rst", base);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
